fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage around the program counter: computes next_pc_if1 (sequential +4 or redirect),
//  issues instruction-memory requests for pc_if1 and pairs in-order responses with their PC.
//  Buffers fetched words in a small queue feeding decode (IF2); flushes on redirect.
//  pc_en is the program-counter advance enable.
// PARAMETERS
//  FQ_DEPTH   2   fetch-queue entries; also max in-flight + queued words (credit limit)
// PORTS
//  clk             in   1   clock
//  reset_n         in   1   asynchronous, active-low reset
//  pc_if1          in   32  current PC from program counter
//  next_pc_if1     out  32  PC to load into program counter when pc_en=1
//  pc_en           out  1   program-counter advance enable
//  redirect_valid  in   1   branch/jump/trap redirect, single-cycle pulse
//  redirect_pc     in   32  redirect target
//  imem_req_valid  out  1   instruction-memory request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  request address (= pc_if1)
//  imem_rsp_valid  in   1   response valid; in order, no backpressure
//  imem_rsp_data   in   32  instruction word
//  inst_valid_if2  out  1   decode-side valid
//  inst_ready_if2  in   1   decode accepts
//  inst_if2        out  32  instruction to decode
//  pc_if2          out  32  PC of inst_if2
// BEHAVIOUR
//  - Reset: queue empty, outstanding=0, drop_cnt=0; imem_req_valid=0, inst_valid_if2=0,
//    inst_if2=0, pc_if2=0, pc_en=0. next_pc_if1 is combinational from pc_if1 (+4).
//  - occupancy = queue count + outstanding (+ pushes/pops this cycle not counted);
//    imem_req_valid = (occupancy < FQ_DEPTH) && !redirect_valid.
//  - imem_req_addr = pc_if1; request may be withdrawn by a redirect before acceptance.
//  - Accept = imem_req_valid && imem_req_ready: push pc_if1 into PC-tag FIFO, outstanding+1.
//  - next_pc_if1 = redirect_valid ? {redirect_pc[31:2],2'b00} : pc_if1 + 32'd4 (mod 2^32,
//    0xFFFF_FFFC wraps to 0). pc_en = accept || redirect_valid.
//  - Response with drop_cnt==0: pop PC tag, push {pc,data} to queue, outstanding-1.
//    Response with drop_cnt>0: discarded, drop_cnt-1, outstanding-1, tag popped.
//  - Latency: rsp in cycle M -> inst_valid_if2 in M+1 (registered queue, no bypass).
//  - Queue pop on inst_valid_if2 && inst_ready_if2; push and pop same cycle legal when full.
//    Credit rule guarantees a response never finds the queue full; overflow is an assertion.
//  - Outputs inst_if2/pc_if2 hold stable while inst_valid_if2 && !inst_ready_if2.
//  - Redirect cycle: queue flushed (inst_valid_if2=0 next cycle), no new request,
//    drop_cnt <= outstanding minus any response arriving that same cycle; the response
//    arriving in the redirect cycle is itself discarded. New fetch at redirect_pc next cycle.
//  - Redirect while drop_cnt>0: drop_cnt accumulates likewise; never underflows.
//  - Reset mid-operation: all state cleared asynchronously; in-flight responses after
//    reset release are the memory's responsibility (memory reset together).
//  - Counters sized $clog2(FQ_DEPTH+1); imem_rsp_valid with outstanding==0 -> assertion.
// STRUCTURE
//  - fetch_pkg: RESET_PC = 32'h8000_0000, INST_NOP = 32'h0000_0013,
//    typedef struct packed {logic [31:0] pc; logic [31:0] inst;} fetch_entry_t.
//  - Sub-module fetch_fifo #(type T, DEPTH): sync FIFO with flush; instantiated twice
//    (PC tags, fetch queue). Credit/drop counters and next-PC mux in fetch_stage.
// TESTING
//  1 Streaming: PC 0x8000_0000, ready=1, 1-cycle rsp, decode ready -> pc_if2 sequence
//    0x8000_0000, _0004, _0008 one per cycle; pc_en high every cycle.
//  2 Decode stall: inst_ready_if2=0 for 5 cycles -> at most FQ_DEPTH=2 requests accepted,
//    imem_req_valid=0, inst_if2/pc_if2 held; release -> resumes in order, no loss/dup.
//  3 Memory backpressure: imem_req_ready=0 for 3 cycles -> pc_en=0, next_pc_if1=pc_if1+4,
//    addr stable; no queue activity.
//  4 Redirect with 2 outstanding: redirect_pc=0x8000_0100 -> both stale responses dropped,
//    next valid pc_if2=0x8000_0100; redirect_pc=0x8000_0103 -> fetch at 0x8000_0100.
//  5 Redirect coincident with response and decode pop -> response dropped, queue empty next.
//  6 Wrap: pc_if1=0xFFFF_FFFC accepted -> next_pc_if1=0x0000_0000; reset asserted
//    mid-stream -> all outputs zero immediately, no valid until new requests.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush. The head entry is read straight out of the
// register array, so an entry pushed in cycle M is visible at the output in M+1.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  T                             i_data,
    input  logic                         i_pop,
    output T                             o_data,
    output logic                         o_empty,
    output logic                         o_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic           w_do_push;
    logic           w_do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage, pointers and occupancy; flush empties the FIFO and beats any push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: next-PC selection, credit-limited instruction-memory requests,
// in-order response/PC pairing and a small fetch queue towards decode.
// A redirect flushes the queue and marks every in-flight response for dropping.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_if1,
    output logic [31:0] next_pc_if1,
    output logic        pc_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid_if2,
    input  logic        inst_ready_if2,
    output logic [31:0] inst_if2,
    output logic [31:0] pc_if2
);

    localparam int            CW        = $clog2(FQ_DEPTH + 1);
    localparam logic [CW:0]   OCC_LIMIT = (CW + 1)'(FQ_DEPTH);

    logic           r_active;
    logic [CW-1:0]  r_outstanding;
    logic [CW-1:0]  r_drop_cnt;

    logic [CW:0]    w_occupancy;
    logic           w_accept;
    logic           w_rsp_keep;
    logic           w_q_pop;
    logic [CW-1:0]  w_q_count;
    logic           w_q_empty;
    logic           w_q_full;
    fetch_entry_t   w_q_in;
    fetch_entry_t   w_q_head;
    logic [31:0]    w_rsp_pc;
    logic [CW-1:0]  w_tag_count;
    logic           w_tag_empty;
    logic           w_tag_full;

    // Credits cover both queued words and words still in flight, so a response
    // always has a free queue slot waiting for it.
    assign w_occupancy    = {1'b0, w_q_count} + {1'b0, r_outstanding};
    assign imem_req_valid = r_active && (w_occupancy < OCC_LIMIT) && !redirect_valid;
    assign imem_req_addr  = pc_if1;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign pc_en          = w_accept || redirect_valid;
    assign next_pc_if1    = redirect_valid ? align_pc(redirect_pc) : pc_if1 + 32'd4;

    // A response landing in the redirect cycle belongs to the old path as well.
    assign w_rsp_keep     = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
    assign w_q_in         = fetch_entry_t'{pc: w_rsp_pc, inst: imem_rsp_data};
    assign w_q_pop        = inst_valid_if2 && inst_ready_if2;

    assign inst_valid_if2 = !w_q_empty;
    assign inst_if2       = w_q_head.inst;
    assign pc_if2         = w_q_head.pc;

    // PC tags of accepted requests; popped by every response, kept or dropped.
    fetch_fifo #(
        .T     (logic [31:0]),
        .DEPTH (FQ_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_flush (1'b0),
        .i_push  (w_accept),
        .i_data  (pc_if1),
        .i_pop   (imem_rsp_valid),
        .o_data  (w_rsp_pc),
        .o_empty (w_tag_empty),
        .o_full  (w_tag_full),
        .o_count (w_tag_count)
    );

    fetch_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_q (
        .clk     (clk),
        .reset_n (reset_n),
        .i_flush (redirect_valid),
        .i_push  (w_rsp_keep),
        .i_data  (w_q_in),
        .i_pop   (w_q_pop),
        .o_data  (w_q_head),
        .o_empty (w_q_empty),
        .o_full  (w_q_full),
        .o_count (w_q_count)
    );

    // Request gating after reset, outstanding-request and drop counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active      <= 1'b0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_active <= 1'b1;

            case ({w_accept, imem_rsp_valid})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            // Everything still in flight after this cycle is stale; that already
            // includes responses an earlier redirect marked for dropping.
            if (redirect_valid) begin
                r_drop_cnt <= imem_rsp_valid ? r_outstanding - CW'(1) : r_outstanding;
            end else if (imem_rsp_valid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

`ifndef SYNTHESIS
    // Protocol and credit-accounting invariants.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(imem_rsp_valid && (r_outstanding == '0)));
            assert (!(imem_rsp_valid && w_tag_empty));
            assert (!(w_accept && w_tag_full));
            assert (!(w_rsp_keep && w_q_full && !w_q_pop));
            assert (w_tag_count == r_outstanding);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a PC register model, an in-order memory
// model of configurable latency and a scoreboard of expected {pc, inst} pairs.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc_if1;
    logic [31:0] next_pc_if1;
    logic        pc_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid_if2;
    logic        inst_ready_if2;
    logic [31:0] inst_if2;
    logic [31:0] pc_if2;

    int n_asserts = 0;
    int n_fail    = 0;

    int           cyc;
    int           mem_lat = 1;
    int           last_due;
    int           n_out;
    logic [31:0]  mq_addr [$];
    int           mq_due  [$];
    fetch_entry_t exp_q   [$];
    logic [31:0]  pop_log [$];
    fetch_entry_t mon_e;

    always #5 clk = ~clk;

    fetch_stage #(.FQ_DEPTH(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pc_if1         (pc_if1),
        .next_pc_if1    (next_pc_if1),
        .pc_en          (pc_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid_if2 (inst_valid_if2),
        .inst_ready_if2 (inst_ready_if2),
        .inst_if2       (inst_if2),
        .pc_if2         (pc_if2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] pop_at(input int idx);
        return (pop_log.size() > idx) ? pop_log[idx] : 32'hDEAD_DEAD;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Program counter register
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)   pc_if1 <= RESET_PC;
        else if (pc_en) pc_if1 <= next_pc_if1;
    end

    // Memory model, scoreboard push on accept, scoreboard clear on redirect
    always @(posedge clk or negedge reset_n) begin
        int due;
        if (!reset_n) begin
            mq_addr.delete();
            mq_due.delete();
            exp_q.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
            n_out    = 0;
            cyc      = 0;
            last_due = 0;
        end else begin
            cyc++;
            if (imem_rsp_valid) n_out--;
            if (redirect_valid) exp_q.delete();
            if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mem_word(mq_addr[0]);
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
                imem_rsp_data  <= 32'hBAD0_BAD0;
            end
            if (imem_req_valid && imem_req_ready) begin
                due = cyc + mem_lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq_addr.push_back(pc_if1);
                mq_due.push_back(due);
                exp_q.push_back(fetch_entry_t'{pc: pc_if1, inst: mem_word(pc_if1)});
                n_out++;
            end
        end
    end

    // Per-cycle interface checks and scoreboard compare on each decode handshake
    always @(negedge clk) begin
        if (reset_n) begin
            check("req_addr", imem_req_addr, pc_if1);
            check("pc_en", {31'b0, pc_en},
                  {31'b0, (imem_req_valid && imem_req_ready) || redirect_valid});
            check("next_pc", next_pc_if1,
                  redirect_valid ? {redirect_pc[31:2], 2'b00} : pc_if1 + 32'd4);
            if (inst_valid_if2 && inst_ready_if2) begin
                n_asserts++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sb_unexpected: observed pc=0x%08h expected no output", pc_if2);
                end
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("sb_pc_if2", pc_if2, mon_e.pc);
                    check("sb_inst_if2", inst_if2, mon_e.inst);
                end
                pop_log.push_back(pc_if2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          p0;
        logic [31:0] pbp;

        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        inst_ready_if2 = 1'b0;

        // Reset state
        #12;
        check("rst_inst_valid", {31'b0, inst_valid_if2}, 32'd0);
        check("rst_inst_if2", inst_if2, 32'd0);
        check("rst_pc_if2", pc_if2, 32'd0);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_pc_en", {31'b0, pc_en}, 32'd0);
        check("rst_next_pc", next_pc_if1, RESET_PC + 32'd4);

        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        check("rel_req_valid", {31'b0, imem_req_valid}, 32'd0);

        // 1: streaming
        imem_req_ready = 1'b1;
        inst_ready_if2 = 1'b1;
        step(1);
        check("s1_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("s1_addr", imem_req_addr, RESET_PC);
        check("s1_pc_en", {31'b0, pc_en}, 32'd1);
        check("s1_next_pc", next_pc_if1, 32'h8000_0004);
        for (int k = 0; k < 40; k++) begin
            if (pop_log.size() >= 3) break;
            step(1);
        end
        check("s1_pop0", pop_at(0), 32'h8000_0000);
        check("s1_pop1", pop_at(1), 32'h8000_0004);
        check("s1_pop2", pop_at(2), 32'h8000_0008);

        // 2: decode stall for 5 cycles
        inst_ready_if2 = 1'b0;
        step(2);
        check("s2_hold_pc_a", pc_if2, (exp_q.size() > 0) ? exp_q[0].pc : 32'hDEAD_DEAD);
        step(2);
        check("s2_req_blocked", {31'b0, imem_req_valid}, 32'd0);
        check("s2_valid", {31'b0, inst_valid_if2}, 32'd1);
        check("s2_inflight", exp_q.size(), 32'd2);
        check("s2_hold_pc_b", pc_if2, (exp_q.size() > 0) ? exp_q[0].pc : 32'hDEAD_DEAD);
        check("s2_hold_inst", inst_if2, (exp_q.size() > 0) ? exp_q[0].inst : 32'hDEAD_DEAD);
        step(1);
        inst_ready_if2 = 1'b1;
        p0 = pop_log.size();
        for (int k = 0; k < 40; k++) begin
            if (pop_log.size() >= p0 + 4) break;
            step(1);
        end
        check("s2_resume", {31'b0, pop_log.size() >= p0 + 4}, 32'd1);

        // 3: memory backpressure
        imem_req_ready = 1'b0;
        #1;
        pbp = pc_if1;
        for (int k = 0; k < 3; k++) begin
            check("s3_pc_en", {31'b0, pc_en}, 32'd0);
            check("s3_addr", imem_req_addr, pbp);
            check("s3_next_pc", next_pc_if1, pbp + 32'd4);
            step(1);
        end
        check("s3_drained", {31'b0, inst_valid_if2}, 32'd0);
        check("s3_sb_empty", exp_q.size(), 32'd0);

        // 4a: redirect with two requests outstanding
        mem_lat = 3;
        imem_req_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (n_out == 2 && !imem_rsp_valid) break;
        end
        check("s4_two_out", n_out, 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        #1;
        check("s4_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("s4_pc_en", {31'b0, pc_en}, 32'd1);
        check("s4_next_pc", next_pc_if1, 32'h8000_0100);
        step(1);
        redirect_valid = 1'b0;
        check("s4_flushed", {31'b0, inst_valid_if2}, 32'd0);
        p0 = pop_log.size();
        for (int k = 0; k < 40; k++) begin
            if (pop_log.size() > p0) break;
            step(1);
        end
        check("s4_first_pc", pop_at(p0), 32'h8000_0100);

        // 4b: back-to-back redirects, second one unaligned and while dropping
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (n_out == 2 && !imem_rsp_valid) break;
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        step(1);
        redirect_pc    = 32'h8000_0103;
        #1;
        check("s4_align", next_pc_if1, 32'h8000_0100);
        step(1);
        redirect_valid = 1'b0;
        p0 = pop_log.size();
        for (int k = 0; k < 40; k++) begin
            if (pop_log.size() > p0) break;
            step(1);
        end
        check("s4_realign_pc", pop_at(p0), 32'h8000_0100);

        // 5: redirect coincident with a response and a decode pop
        mem_lat = 1;
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (inst_valid_if2 && imem_rsp_valid) break;
        end
        check("s5_coincident", {31'b0, inst_valid_if2 && imem_rsp_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0400;
        step(1);
        redirect_valid = 1'b0;
        check("s5_empty_next", {31'b0, inst_valid_if2}, 32'd0);
        p0 = pop_log.size();
        for (int k = 0; k < 40; k++) begin
            if (pop_log.size() > p0) break;
            step(1);
        end
        check("s5_first_pc", pop_at(p0), 32'h8000_0400);

        // 6: wrap at the top of the address space, then reset mid-stream
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step(1);
        redirect_valid = 1'b0;
        p0 = pop_log.size();
        for (int k = 0; k < 30; k++) begin
            if (imem_req_valid && imem_req_ready && imem_req_addr == 32'hFFFF_FFFC) break;
            step(1);
        end
        check("s6_wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        check("s6_wrap_next", next_pc_if1, 32'h0000_0000);
        check("s6_wrap_pc_en", {31'b0, pc_en}, 32'd1);
        for (int k = 0; k < 40; k++) begin
            if (pop_log.size() >= p0 + 3) break;
            step(1);
        end
        check("s6_pop_fff8", pop_at(p0), 32'hFFFF_FFF8);
        check("s6_pop_fffc", pop_at(p0 + 1), 32'hFFFF_FFFC);
        check("s6_pop_zero", pop_at(p0 + 2), 32'h0000_0000);

        for (int k = 0; k < 20; k++) begin
            if (inst_valid_if2) break;
            step(1);
        end
        reset_n = 1'b0;
        #1;
        check("s6_rst_valid", {31'b0, inst_valid_if2}, 32'd0);
        check("s6_rst_inst", inst_if2, 32'd0);
        check("s6_rst_pc_if2", pc_if2, 32'd0);
        check("s6_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("s6_rst_pc_en", {31'b0, pc_en}, 32'd0);
        step(2);
        p0 = pop_log.size();
        reset_n = 1'b1;
        #1;
        check("s6_rel_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("s6_rel_inst_valid", {31'b0, inst_valid_if2}, 32'd0);
        step(1);
        check("s6_restart_addr", imem_req_addr, RESET_PC);
        check("s6_restart_req", {31'b0, imem_req_valid}, 32'd1);
        for (int k = 0; k < 40; k++) begin
            if (pop_log.size() >= p0 + 2) break;
            step(1);
        end
        check("s6_restart_pop0", pop_at(p0), RESET_PC);
        check("s6_restart_pop1", pop_at(p0 + 1), RESET_PC + 32'd4);

        imem_req_ready = 1'b0;
        step(5);
        check("end_sb_empty", exp_q.size(), 32'd0);
        check("end_inst_valid", {31'b0, inst_valid_if2}, 32'd0);
        check("end_outstanding", n_out, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
